mmio_ctrl: RTL and testbench



---
 rtl/mmio_pkg.sv | 16 +
 rtl/debounce_ch.sv | 43 ++++
 rtl/mmio_ctrl.sv | 127 ++++++++++++
 tb/tb_mmio_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - register map and status layout shared by the mmio controller
package mmio_pkg;

  localparam int WIN_WORDS = 16;
  localparam int OFF_W     = $clog2(WIN_WORDS);

  localparam logic [OFF_W-1:0] OFF_LED     = 4'h0;
  localparam logic [OFF_W-1:0] OFF_STATUS  = 4'h1;
  localparam logic [OFF_W-1:0] OFF_TMR_CMP = 4'h2;
  localparam logic [OFF_W-1:0] OFF_TMR_CNT = 4'h3;
  localparam logic [OFF_W-1:0] OFF_IN_BASE = 4'h4;

  localparam int STAT_TMR_BIT = 0;
  localparam int STAT_IN_BASE = 1;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one switch channel: two-flop synchroniser, debounce counter, stable register
module debounce_ch #(
  parameter int IN_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] raw,
  output logic [IN_WIDTH-1:0] stable,
  output logic                changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync2;
  logic [CNT_W-1:0]    cnt;

  // Pulses on the edge where stable takes the new value.
  assign changed = (sync2 != stable) && (cnt == CNT_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (changed) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - I/O window decode, LED/status/timer registers and read path in front of the data RAM
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 12,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    NUM_IN          = 2,
  parameter int                    IN_WIDTH        = 8,
  parameter int                    LED_WIDTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE         = 12'hFF0,
  parameter int                    DEBOUNCE_CYCLES = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wren,
  input  logic [ADDR_WIDTH-1:0]      address_dmem,
  input  logic [DATA_WIDTH-1:0]      data,
  output logic [DATA_WIDTH-1:0]      q_dmem,
  output logic                       ram_wEn,
  output logic [ADDR_WIDTH-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0]      ram_dataIn,
  input  logic [DATA_WIDTH-1:0]      ram_dataOut,
  input  logic [NUM_IN*IN_WIDTH-1:0] sw_in,
  output logic [LED_WIDTH-1:0]       led
);

  logic             hit;
  logic [OFF_W-1:0] off;
  logic             io_wr;

  assign hit   = (address_dmem[ADDR_WIDTH-1:OFF_W] == IO_BASE[ADDR_WIDTH-1:OFF_W]);
  assign off   = address_dmem[OFF_W-1:0];
  assign io_wr = wren && hit;

  assign ram_wEn    = wren && !hit;
  assign ram_addr   = address_dmem;
  assign ram_dataIn = data;

  logic [IN_WIDTH-1:0] in_stable [NUM_IN];
  logic [NUM_IN-1:0]   in_chg;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    debounce_ch #(
      .IN_WIDTH       (IN_WIDTH),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock  (clock),
      .reset  (reset),
      .raw    (sw_in[k*IN_WIDTH +: IN_WIDTH]),
      .stable (in_stable[k]),
      .changed(in_chg[k])
    );
  end

  logic [LED_WIDTH-1:0]  led_q;
  logic [NUM_IN:0]       status_q;
  logic [DATA_WIDTH-1:0] tmr_cmp;
  logic [DATA_WIDTH-1:0] tmr_cnt;
  logic                  tmr_match;
  logic [NUM_IN:0]       sts_set;
  logic [NUM_IN:0]       sts_clr;

  assign led       = led_q;
  assign tmr_match = (tmr_cmp != '0) && (tmr_cnt == tmr_cmp);

  always_comb begin
    sts_set = '0;
    sts_set[STAT_TMR_BIT] = tmr_match;
    sts_set[STAT_IN_BASE +: NUM_IN] = in_chg;
    sts_clr = (io_wr && off == OFF_STATUS) ? data[NUM_IN:0] : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      status_q <= '0;
      tmr_cmp  <= '0;
      tmr_cnt  <= '0;
    end else begin
      if (io_wr && off == OFF_LED) led_q <= data[LED_WIDTH-1:0];
      // Set is ORed after the clear so a same-cycle event survives W1C.
      status_q <= (status_q & ~sts_clr) | sts_set;
      if (io_wr && off == OFF_TMR_CMP) begin
        tmr_cmp <= data;
        tmr_cnt <= '0;
      end else if (tmr_match) begin
        tmr_cnt <= '0;
      end else begin
        tmr_cnt <= tmr_cnt + 1'b1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_LED:     rd_val[LED_WIDTH-1:0] = led_q;
      OFF_STATUS:  rd_val[NUM_IN:0] = status_q;
      OFF_TMR_CMP: rd_val = tmr_cmp;
      OFF_TMR_CNT: rd_val = tmr_cnt;
      default: begin
        for (int k = 0; k < NUM_IN; k++) begin
          if (off == OFF_IN_BASE + OFF_W'(k)) rd_val[IN_WIDTH-1:0] = in_stable[k];
        end
      end
    endcase
  end

  logic                  hit_q;
  logic [DATA_WIDTH-1:0] rd_q;

  // hit_q resets to 1 so q_dmem reads the cleared rd_q, not the RAM, during reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b1;
      rd_q  <= '0;
    end else begin
      hit_q <= hit;
      rd_q  <= rd_val;
    end
  end

  assign q_dmem = hit_q ? rd_q : ram_dataOut;

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - self-checking bench for mmio_ctrl with a RAM model and randomised stimulus
module tb_mmio_ctrl;

  localparam int DEB = 16;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [11:0] ram_addr;
  logic [31:0] ram_dataIn;
  logic [31:0] ram_dataOut;
  logic [15:0] sw_in;
  logic [15:0] led;

  int errors = 0;
  int checks = 0;

  mmio_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_dmem      (q_dmem),
    .ram_wEn     (ram_wEn),
    .ram_addr    (ram_addr),
    .ram_dataIn  (ram_dataIn),
    .ram_dataOut (ram_dataOut),
    .sw_in       (sw_in),
    .led         (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [4096];
  always @(posedge clock) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    ram_dataOut <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    wren = 1'b1; address_dmem = a; data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic load(input logic [11:0] a);
    wren = 1'b0; address_dmem = a;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; wren = 1'b0; address_dmem = 12'h000; data = '0; sw_in = '0;
    #2;
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected 0000", led); end
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected 00000000", q_dmem); end
    wren = 1'b1; address_dmem = 12'h010; data = 32'h55;
    #1;
    checks++; if (ram_wEn !== 1'b1 || ram_addr !== 12'h010) begin
      errors++; $display("FAIL reset_passthru: got wEn=%b addr=%h expected wEn=1 addr=010", ram_wEn, ram_addr);
    end
    wren = 1'b0;
    @(posedge clock); #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    logic [11:0] a;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 12'h010 : 12'($urandom_range(0, 12'hFEF));
      d = (i == 0) ? 32'h1234 : $urandom;
      wren = 1'b1; address_dmem = a; data = d;
      #1;
      checks++; if (ram_wEn !== 1'b1 || ram_addr !== a || ram_dataIn !== d) begin
        errors++; $display("FAIL pass_store: got wEn=%b addr=%h din=%h expected 1 %h %h", ram_wEn, ram_addr, ram_dataIn, a, d);
      end
      tick();
      wren = 1'b0;
      load(a);
      checks++; if (q_dmem !== d) begin errors++; $display("FAIL pass_load: got %h expected %h", q_dmem, d); end
      checks++; if (led !== 16'h0) begin errors++; $display("FAIL pass_led: got %h expected 0000", led); end
    end
  endtask

  task automatic test_led();
    logic [31:0] v;
    logic [31:0] prev;
    prev = 32'h0;
    for (int i = 0; i < 4; i++) begin
      v = (i == 0) ? 32'h0000BEEF : $urandom;
      wren = 1'b1; address_dmem = 12'hFF0; data = v;
      #1;
      checks++; if (ram_wEn !== 1'b0) begin errors++; $display("FAIL led_ram_wen: got %b expected 0", ram_wEn); end
      tick();
      wren = 1'b0;
      checks++; if (led !== v[15:0]) begin errors++; $display("FAIL led_value: got %h expected %h", led, v[15:0]); end
      checks++; if (q_dmem !== {16'h0, prev[15:0]}) begin
        errors++; $display("FAIL led_same_cycle_read: got %h expected %h", q_dmem, {16'h0, prev[15:0]});
      end
      load(12'hFF0);
      checks++; if (q_dmem !== {16'h0, v[15:0]}) begin errors++; $display("FAIL led_readback: got %h expected %h", q_dmem, {16'h0, v[15:0]}); end
      prev = v;
    end
    store(12'hFF9, $urandom);
    load(12'hFF9);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", q_dmem); end
    store(12'hFF4, 32'hFF);
    load(12'hFF4);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL ro_in_write: got %h expected 0", q_dmem); end
  endtask

  task automatic test_debounce();
    logic [31:0] exp;
    load(12'hFF1);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL deb_status_pre: got %h expected 0", q_dmem); end
    for (int i = 0; i < 10; i++) begin
      sw_in[7:0] = (i == 9 || $urandom_range(0, 1) == 0) ? 8'h00 : 8'h5A;
      load(12'hFF4);
      checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL deb_glitch: got %h expected 0", q_dmem); end
    end
    sw_in[7:0] = 8'h5A;
    // stable updates on edge 2+DEB after the hold begins; the read shows it one edge later
    for (int k = 1; k <= DEB + 3; k++) begin
      load(12'hFF4);
      exp = (k >= DEB + 3) ? 32'h5A : 32'h0;
      checks++; if (q_dmem !== exp) begin errors++; $display("FAIL deb_hold edge %0d: got %h expected %h", k, q_dmem, exp); end
    end
    load(12'hFF1);
    checks++; if (q_dmem !== 32'h2) begin errors++; $display("FAIL deb_status: got %h expected 2", q_dmem); end
    store(12'hFF1, 32'h2);
    load(12'hFF1);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL deb_w1c: got %h expected 0", q_dmem); end
    load(12'hFF5);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL deb_ch1: got %h expected 0", q_dmem); end
  endtask

  task automatic test_timer();
    int n;
    logic [31:0] exp;
    for (int r = 0; r < 3; r++) begin
      n = (r == 0) ? 4 : int'($urandom_range(2, 8));
      store(12'hFF2, 32'h0);
      store(12'hFF1, 32'h1);
      store(12'hFF2, 32'(n));
      for (int j = 1; j <= n + 2; j++) begin
        load(12'hFF1);
        exp = (j >= n + 2) ? 32'h1 : 32'h0;
        checks++; if (q_dmem !== exp) begin errors++; $display("FAIL tmr_flag n=%0d j=%0d: got %h expected %h", n, j, q_dmem, exp); end
      end
      store(12'hFF2, 32'(n));
      for (int j = 1; j <= 2 * (n + 1); j++) begin
        load(12'hFF3);
        exp = 32'((j - 1) % (n + 1));
        checks++; if (q_dmem !== exp) begin errors++; $display("FAIL tmr_cnt n=%0d j=%0d: got %h expected %h", n, j, q_dmem, exp); end
      end
    end
    store(12'hFF2, 32'h0);
    repeat (5) load(12'h100);
    load(12'hFF3);
    checks++; if (q_dmem !== 32'd5) begin errors++; $display("FAIL tmr_freerun: got %h expected 5", q_dmem); end
    store(12'hFF1, 32'h1);
    repeat (30) load(12'h100);
    load(12'hFF1);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL tmr_no_flag: got %h expected 0", q_dmem); end
  endtask

  task automatic test_collision();
    int n;
    for (int r = 0; r < 2; r++) begin
      n = int'($urandom_range(2, 8));
      store(12'hFF2, 32'h0);
      store(12'hFF1, 32'hFFFF_FFFF);
      store(12'hFF2, 32'(n));
      repeat (n) load(12'h100);
      store(12'hFF1, 32'h1);
      load(12'hFF1);
      checks++; if (q_dmem !== 32'h1) begin errors++; $display("FAIL collision_set_wins n=%0d: got %h expected 1", n, q_dmem); end
      store(12'hFF1, 32'h1);
      load(12'hFF1);
      checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL collision_clear n=%0d: got %h expected 0", n, q_dmem); end
    end
    store(12'hFF2, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    v = $urandom | 32'h1;
    store(12'hFF0, v);
    store(12'hFF2, 32'h2);
    sw_in[7:0] = 8'h33;
    repeat (8) load(12'h100);
    load(12'hFF0);
    checks++; if (q_dmem !== {16'h0, v[15:0]}) begin errors++; $display("FAIL rst_pre_q: got %h expected %h", q_dmem, {16'h0, v[15:0]}); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL rst_mid_led: got %h expected 0000", led); end
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL rst_mid_q: got %h expected 0", q_dmem); end
    @(posedge clock); #3;
    reset = 1'b0;
    load(12'hFF4);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL rst_in0: got %h expected 0", q_dmem); end
    load(12'hFF1);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", q_dmem); end
    load(12'hFF2);
    checks++; if (q_dmem !== 32'h0) begin errors++; $display("FAIL rst_tmr_cmp: got %h expected 0", q_dmem); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_led();
    test_debounce();
    test_timer();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
